cia_access_arbiter: RTL

Shares one 6526/8520 CIA register port between two requesters: the CPU side (port `c`) and a background engine such as a keyboard scanner or fast-serial sequencer (port `h`). It issues at most one CIA bus cycle per Phi2 period, aligned to the `phi2_p`/`phi2_n` strobes, and returns read data with a single-cycle acknowledge. It also shadows the read-to-clear ICR (register $D), so that helper ICR reads never lose interrupt flags the CPU has not yet seen.

---
 rtl/cia_pkg.sv | 30 +++
 rtl/cia_icr_shadow.sv | 29 ++
 rtl/cia_access_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cia_pkg.sv
// Shared definitions for the CIA access arbiter: register map, FSM states
// and the latched request format.
package cia_pkg;

  localparam logic [3:0] CIA_PRA    = 4'h0;
  localparam logic [3:0] CIA_PRB    = 4'h1;
  localparam logic [3:0] CIA_DDRA   = 4'h2;
  localparam logic [3:0] CIA_DDRB   = 4'h3;
  localparam logic [3:0] CIA_TALO   = 4'h4;
  localparam logic [3:0] CIA_TAHI   = 4'h5;
  localparam logic [3:0] CIA_TBLO   = 4'h6;
  localparam logic [3:0] CIA_TBHI   = 4'h7;
  localparam logic [3:0] CIA_TOD10  = 4'h8;
  localparam logic [3:0] CIA_TODSEC = 4'h9;
  localparam logic [3:0] CIA_TODMIN = 4'hA;
  localparam logic [3:0] CIA_TODHR  = 4'hB;
  localparam logic [3:0] CIA_SDR    = 4'hC;
  localparam logic [3:0] CIA_ICR    = 4'hD;
  localparam logic [3:0] CIA_CRA    = 4'hE;
  localparam logic [3:0] CIA_CRB    = 4'hF;

  typedef enum logic [1:0] {IDLE, GRANT, STROBE, CAPTURE} cia_state_e;

  typedef struct packed {
    logic       rw;
    logic [3:0] rs;
    logic [7:0] wdata;
  } cia_req_t;

endpackage

// File: rtl/cia_icr_shadow.sv
// Shadow of the read-to-clear ICR: collects flags the helper consumed so the
// CPU still sees them on its next ICR read.
module cia_icr_shadow
  import cia_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_merge,
  input  logic       i_clear,
  input  logic [7:0] i_icr,
  output logic [7:0] o_shadow
);

  // bit 5 holds the IRQ flag (ICR bit 7), bits 4:0 the source flags
  logic [5:0] r_flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= 6'd0;
    end else if (i_clear) begin
      r_flags <= 6'd0;
    end else if (i_merge) begin
      r_flags <= r_flags | {i_icr[7], i_icr[4:0]};
    end
  end

  assign o_shadow = {r_flags[5], 2'b00, r_flags[4:0]};

endmodule

// File: rtl/cia_access_arbiter.sv
// Shares one CIA register port between the CPU and a helper engine, one bus
// cycle per Phi2 period, with a bounded wait for the helper.
module cia_access_arbiter
  import cia_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       phi2_p,
  input  logic       phi2_n,
  input  logic       c_req,
  input  logic       h_req,
  input  logic       c_rw,
  input  logic       h_rw,
  input  logic [3:0] c_rs,
  input  logic [3:0] h_rs,
  input  logic [7:0] c_wdata,
  input  logic [7:0] h_wdata,
  output logic       c_ack,
  output logic       h_ack,
  output logic [7:0] c_rdata,
  output logic [7:0] h_rdata,
  output logic       cia_cs_n,
  output logic       cia_rw,
  output logic [3:0] cia_rs,
  output logic [7:0] cia_db_in,
  input  logic [7:0] cia_db_out
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  cia_state_e    r_state;
  cia_state_e    w_next;
  cia_req_t      r_req;
  cia_req_t      w_sel;
  logic          r_owner_h;
  logic [CW-1:0] r_wait;
  logic          r_c_ack, r_h_ack;
  logic [7:0]    r_c_rdata, r_h_rdata;
  logic          w_grant, w_h_wins, w_done, w_active;
  logic          w_icr_rd, w_h_icr_rd, w_c_icr_rd;
  logic [7:0]    w_shadow;

  assign w_grant  = (r_state == IDLE) && phi2_p && (c_req || h_req);
  assign w_h_wins = h_req && (!c_req || (r_wait == CW'(MAX_WAIT)));
  assign w_sel    = w_h_wins ? cia_req_t'{h_rw, h_rs, h_wdata}
                             : cia_req_t'{c_rw, c_rs, c_wdata};
  // the CIA has sampled the bus by the end of STROBE, so that edge completes
  assign w_done     = (r_state == STROBE);
  assign w_icr_rd   = w_done && r_req.rw && (r_req.rs == CIA_ICR);
  assign w_h_icr_rd = w_icr_rd && r_owner_h;
  assign w_c_icr_rd = w_icr_rd && !r_owner_h;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next = GRANT;
      GRANT:   if (phi2_n) w_next = STROBE;
      STROBE:  w_next = CAPTURE;
      CAPTURE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_active  = (r_state == GRANT) || (r_state == STROBE);
    cia_cs_n  = !w_active;
    cia_rw    = w_active ? r_req.rw : 1'b1;
    cia_rs    = w_active ? r_req.rs : 4'h0;
    cia_db_in = w_active ? r_req.wdata : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req     <= cia_req_t'{1'b1, 4'h0, 8'h00};
      r_owner_h <= 1'b0;
      r_wait    <= '0;
    end else begin
      if (w_grant) begin
        r_req     <= w_sel;
        r_owner_h <= w_h_wins;
      end
      // the wait count only means something while the helper is asking
      if (!h_req || (w_grant && w_h_wins)) begin
        r_wait <= '0;
      end else if (w_grant && (r_wait != CW'(MAX_WAIT))) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_c_ack   <= 1'b0;
      r_h_ack   <= 1'b0;
      r_c_rdata <= 8'h00;
      r_h_rdata <= 8'h00;
    end else begin
      r_c_ack <= w_done && !r_owner_h;
      r_h_ack <= w_done && r_owner_h;
      if (w_done && r_req.rw) begin
        if (r_owner_h) begin
          r_h_rdata <= cia_db_out;
        end else begin
          r_c_rdata <= cia_db_out | (w_c_icr_rd ? w_shadow : 8'h00);
        end
      end
    end
  end

  cia_icr_shadow u_icr_shadow (
    .clk      (clk),
    .reset    (reset),
    .i_merge  (w_h_icr_rd),
    .i_clear  (w_c_icr_rd),
    .i_icr    (cia_db_out),
    .o_shadow (w_shadow)
  );

  assign c_ack   = r_c_ack;
  assign h_ack   = r_h_ack;
  assign c_rdata = r_c_rdata;
  assign h_rdata = r_h_rdata;

endmodule
